// File: rtl/irq_capture.sv
// Request capture ahead of the priority encoder: sync, edge/level detect,
// pending/mask registers, ack-by-code clear and sticky lost flags.
module irq_capture #(
  parameter int          N         = 8,
  parameter int          CW        = 3,
  parameter int          EDGE_MODE = 1,
  parameter logic [N-1:0] MASK_RST = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mask_we,
  input  logic [N-1:0]  mask_wdata,
  output logic [N-1:0]  pend,
  output logic          irq_valid,
  input  logic          ack,
  input  logic [CW-1:0] ack_code,
  output logic [N-1:0]  lost,
  input  logic          lost_clr
);

  logic [N-1:0] s1, s2, p;
  logic [N-1:0] pending, mask, lost_q;
  logic [N-1:0] ev, ackv;
  logic [N-1:0] pending_nx, lost_nx;

  always_comb begin
    ackv = '0;
    for (int i = 0; i < N; i++)
      ackv[i] = ack && (ack_code == CW'(i));
  end

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign ev = s2 & ~p;
      // a fresh event on an acked bit replaces the serviced one
      assign lost_nx = (lost_q & ~{N{lost_clr}})
                     | (ev & pending & ~ackv);
    end else begin : g_level
      assign ev      = s2;
      assign lost_nx = '0;
    end
  endgenerate

  assign pending_nx = ev | (pending & ~ackv);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      p       <= '0;
      pending <= '0;
      lost_q  <= '0;
      mask    <= MASK_RST;
    end else begin
      s1      <= req;
      s2      <= s1;
      p       <= s2;
      pending <= pending_nx;
      lost_q  <= lost_nx;
      if (mask_we)
        mask <= mask_wdata;
    end
  end

  assign pend      = pending & mask;
  assign irq_valid = |pend;
  assign lost      = lost_q;

endmodule

// File: tb/tb_irq_capture.sv
// Directed bench for irq_capture: latency, ack, mask, lost and reset cases.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_irq_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] pend;
  logic       irq_valid;
  logic       ack;
  logic [2:0] ack_code;
  logic [7:0] lost;
  logic       lost_clr;

  int passed = 0;
  int total  = 0;

  irq_capture dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pend(pend), .irq_valid(irq_valid),
    .ack(ack), .ack_code(ack_code),
    .lost(lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask_we = 1'b1; mask_wdata = 8'h00;
    ack = 1'b0; ack_code = 3'd0; lost_clr = 1'b0;
    tick();
    mask_wdata = 8'h5A;
    tick();
    chk("rst_pend", pend, 8'h00);
    chk("rst_irq", {7'd0, irq_valid}, 8'h00);
    chk("rst_lost", lost, 8'h00);
    rst_n = 1'b1; mask_we = 1'b0;
    tick();

    // latency: pending appears at edge k+2
    req = 8'h08;
    tick();
    chk("lat_k", pend, 8'h00);
    tick();
    chk("lat_k1_pend", pend, 8'h00);
    chk("lat_k1_irq", {7'd0, irq_valid}, 8'h00);
    tick();
    chk("lat_k2_pend", pend, 8'h08);
    chk("lat_k2_irq", {7'd0, irq_valid}, 8'h01);
    ack = 1'b1; ack_code = 3'd3;
    tick();
    ack = 1'b0;
    chk("ack3", pend, 8'h00);
    chk("ack3_irq", {7'd0, irq_valid}, 8'h00);
    req = 8'h00;
    ticks(3);

    // two lines, acked one at a time
    req = 8'h42;
    ticks(3);
    chk("two_pend", pend, 8'h42);
    ack = 1'b1; ack_code = 3'd6;
    tick();
    chk("ack6", pend, 8'h02);
    ack_code = 3'd1;
    tick();
    ack = 1'b0;
    chk("ack1", pend, 8'h00);
    chk("ack1_irq", {7'd0, irq_valid}, 8'h00);
    req = 8'h00;
    ticks(3);

    // ack on a non-pending bit is harmless
    req = 8'h10;
    ticks(3);
    ack = 1'b1; ack_code = 3'd2;
    tick();
    ack = 1'b0;
    chk("ack_idle", pend, 8'h10);
    ack = 1'b1; ack_code = 3'd4;
    tick();
    ack = 1'b0;
    req = 8'h00;
    ticks(3);

    // mask hides but keeps pending
    req = 8'h04;
    ticks(3);
    chk("m_pend", pend, 8'h04);
    mask_we = 1'b1; mask_wdata = 8'hFB;
    tick();
    mask_we = 1'b0;
    chk("m_masked", pend, 8'h00);
    chk("m_masked_irq", {7'd0, irq_valid}, 8'h00);
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    chk("m_unmask", pend, 8'h04);
    ack = 1'b1; ack_code = 3'd2;
    tick();
    ack = 1'b0;
    chk("m_ack", pend, 8'h00);
    req = 8'h00;
    ticks(3);

    // second edge while pending -> lost
    req = 8'h20;
    ticks(3);
    chk("l_first", pend, 8'h20);
    chk("l_none", lost, 8'h00);
    req = 8'h00;
    ticks(3);
    req = 8'h20;
    ticks(3);
    chk("l_set", lost, 8'h20);
    chk("l_pend", pend, 8'h20);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    chk("l_clr", lost, 8'h00);
    chk("l_clr_pend", pend, 8'h20);
    req = 8'h00;
    ticks(3);
    req = 8'h20;
    ticks(2);
    ack = 1'b1; ack_code = 3'd5;
    tick();
    ack = 1'b0;
    chk("l_ack_pend", pend, 8'h20);
    chk("l_ack_lost", lost, 8'h00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("l_ack_final", pend, 8'h00);
    req = 8'h00;
    ticks(3);

    // reset discards an in-flight event
    req = 8'h01;
    tick();
    rst_n = 1'b0; req = 8'h00;
    tick();
    rst_n = 1'b1;
    chk("r_flush", pend, 8'h00);
    ticks(3);
    chk("r_flush2", pend, 8'h00);

    // request held through reset fires once
    req = 8'h01; rst_n = 1'b0;
    ticks(2);
    chk("r_hold", pend, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("r_rel0", pend, 8'h00);
    tick();
    chk("r_rel1", pend, 8'h00);
    tick();
    chk("r_rel2", pend, 8'h01);
    ack = 1'b1; ack_code = 3'd0;
    tick();
    ack = 1'b0;
    chk("r_ack", pend, 8'h00);
    ticks(3);
    chk("r_once", pend, 8'h00);
    chk("r_lost", lost, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
